// File: rtl/lat_table_loader.sv
// Latency table loader: five 5-bit jump entries plus a 2-bit clock select,
// serialised MSB first as {CS, J5, J4, J3, J2, J1} (27 bits) on request.
// Latency: first bit the cycle after start is sampled; done frame-length+1 cycles after start.
// Backpressure: none; start in SHIFT is dropped and writes in SHIFT are rejected (sticky err).
// Optional feature: define LAT_LOADER_PARITY_EN to append an even-parity bit as a 28th bit.

module lat_table_loader #(
  parameter int frame_len = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       start,
  output logic       ser_out,
  output logic       ser_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef LAT_LOADER_PARITY_EN
  // Parity bit rides after the frame, so the shifter is one bit longer.
  localparam int SHIFT_LEN = frame_len + 1;
`else
  localparam int SHIFT_LEN = frame_len;
`endif
  localparam int CNT_W = $clog2(SHIFT_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [4:0][4:0]       jmp_q, jmp_d;     // jmp_q[0] is J1 ... jmp_q[4] is J5
  logic [1:0]            cs_q, cs_d;
  logic [SHIFT_LEN-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  can_wr_w;
  logic                  wr_ok_w;
  logic                  wr_rej_w;
  logic                  load_w;
  logic [frame_len-1:0]  frame_w;
  logic [SHIFT_LEN-1:0]  load_dat_w;

  // Table is writable and a new frame may start only outside SHIFT.
  assign can_wr_w = (state_q != ST_SHIFT);
  assign wr_ok_w  = wr_en && (wr_addr <= 3'd5) && can_wr_w;
  assign wr_rej_w = wr_en && !wr_ok_w;
  assign load_w   = start && can_wr_w;

  // Frame is built from the registered table, so a write on the start edge
  // lands in the table but not in the frame being launched.
  assign frame_w = {cs_q, jmp_q};

`ifdef LAT_LOADER_PARITY_EN
  logic parity_w;
  assign parity_w   = ^frame_w;
  assign load_dat_w = {frame_w, parity_w};
`else
  assign load_dat_w = frame_w;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE lasts one cycle and may chain straight into a new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; ser_out is forced low outside SHIFT.
  always_comb begin
    busy    = 1'b0;
    ser_en  = 1'b0;
    ser_out = 1'b0;
    done    = 1'b0;
    err     = err_q;
    case (state_q)
      ST_SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = shift_q[SHIFT_LEN-1];
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Table write decode: address 5 targets the 2-bit clock select.
  always_comb begin
    jmp_d = jmp_q;
    cs_d  = cs_q;
    if (wr_ok_w) begin
      if (wr_addr == 3'd5) begin
        cs_d = wr_data[1:0];
      end else begin
        jmp_d[wr_addr] = wr_data;
      end
    end
  end

  // Shifter and bit counter: load on start, shift left and count down in SHIFT.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_w) begin
      shift_d = load_dat_w;
      cnt_d   = CNT_W'(SHIFT_LEN - 1);
    end else if (state_q == ST_SHIFT) begin
      shift_d = shift_q << 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Sticky error: a rejected write wins over the clear that a frame launch performs.
  always_comb begin
    err_d = err_q;
    if (wr_rej_w) begin
      err_d = 1'b1;
    end else if (load_w) begin
      err_d = 1'b0;
    end
  end

  // Table registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      jmp_q <= '0;
      cs_q  <= '0;
    end else begin
      jmp_q <= jmp_d;
      cs_q  <= cs_d;
    end
  end

  // Serialiser datapath and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lat_table_loader.sv
// Bench for lat_table_loader: directed table scenarios followed by random traffic.
// Expected serial bits and done pulses are queued with their due cycle by the stimulus side
// and consumed by an independent monitor that samples on the falling edge.

module tb_lat_table_loader;

`ifdef LAT_LOADER_PARITY_EN
  localparam int LEN = 28;
`else
  localparam int LEN = 27;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       start = 1'b0;
  logic       ser_out, ser_en, busy, done, err;

  always #5 clk = ~clk;

  lat_table_loader #(.frame_len(27)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .ser_out (ser_out),
    .ser_en  (ser_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind 0 = serial bit with value val, kind 1 = done pulse
  typedef struct {
    int cyc;
    int kind;
    int val;
  } item_t;
  item_t expq[$];

  // Reference model state
  int jm[5];
  int cs;
  int busy_left = 0;     // SHIFT cycles remaining after the edge just modelled
  bit err_now   = 1'b0;  // expected err in the current cycle
  bit err_next  = 1'b0;  // expected err after the coming edge

  // Monitor captures
  longint cap = 0;
  longint last_frame = 0;
  longint prev_frame = 0;
  int     done_cyc = 0;
  int     prev_done_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint table_frame();
    longint f;
    f = longint'(cs) * (64'd1 << 25) + longint'(jm[4]) * (64'd1 << 20) +
        longint'(jm[3]) * (64'd1 << 15) + longint'(jm[2]) * (64'd1 << 10) +
        longint'(jm[1]) * (64'd1 << 5) + longint'(jm[0]);
`ifdef LAT_LOADER_PARITY_EN
    f = f * 2 + longint'($countones(f) % 2);
`endif
    return f;
  endfunction

  // One clock of stimulus; the model predicts what the coming edge does.
  task automatic step(input bit rst, input bit we, input int a, input int d, input bit st);
    bit idle, acc, rej, ld;
    longint f;
    @(posedge clk);
    #1;
    err_now = err_next;
    reset   = rst;
    wr_en   = we;
    wr_addr = a[2:0];
    wr_data = d[4:0];
    start   = st;
    if (rst) begin
      for (int i = 0; i < 5; i++) jm[i] = 0;
      cs = 0;
      busy_left = 0;
      err_next = 1'b0;
      while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
    end else begin
      idle = (busy_left == 0);
      acc  = we && (a <= 5) && idle;
      rej  = we && !acc;
      ld   = st && idle;
      if (ld) begin
        f = table_frame();
        for (int i = 0; i < LEN; i++) begin
          item_t it;
          it.cyc  = cyc + 1 + i;
          it.kind = 0;
          it.val  = int'((f >> (LEN - 1 - i)) & 1);
          expq.push_back(it);
        end
        begin
          item_t dn;
          dn.cyc = cyc + LEN + 1;
          dn.kind = 1;
          dn.val = 0;
          expq.push_back(dn);
        end
      end
      if (acc) begin
        if (a == 5) cs = d % 4;
        else jm[a] = d % 32;
      end
      if (rej) err_next = 1'b1;
      else if (ld) err_next = 1'b0;
      if (ld) busy_left = LEN;
      else if (busy_left > 0) busy_left--;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: consume expected items as the DUT presents them, check every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      bit eb, ed;
      int ev;
      while (expq.size() > 0 && expq[0].cyc < cyc) void'(expq.pop_front());
      eb = 1'b0;
      ed = 1'b0;
      ev = 0;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        if (expq[0].kind == 0) begin
          eb = 1'b1;
          ev = expq[0].val;
        end else begin
          ed = 1'b1;
        end
        void'(expq.pop_front());
      end
      chk("ser_en", ser_en, eb);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("ser_out", ser_out, ev);
      chk("err", err, err_now);
      if (ser_en) cap = (cap << 1) | longint'(ser_out);
      if (done) begin
        prev_frame    = last_frame;
        last_frame    = cap;
        prev_done_cyc = done_cyc;
        done_cyc      = cyc;
        cap           = 0;
      end
      if (reset) cap = 0;
    end
  end

  longint exp_basic;
  longint exp_rand;
  int     s_cyc;

  initial begin
`ifdef LAT_LOADER_PARITY_EN
    exp_basic = {36'd0, 27'b100010100100000110001000001, 1'b0};
`else
    exp_basic = {37'd0, 27'b100010100100000110001000001};
`endif
    for (int i = 0; i < 5; i++) jm[i] = 0;
    cs = 0;

    // Reset and idle state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    mon_on = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    idle_n(2);

    // Known table, single frame, latency
    for (int i = 0; i < 5; i++) step(0, 1, i, i + 1, 0);
    step(0, 1, 5, 2, 0);
    step(0, 0, 0, 0, 1);
    s_cyc = cyc;
    idle_n(LEN + 3);
    chk("basic_frame", last_frame, exp_basic);
    chk("latency", done_cyc - s_cyc, LEN + 1);

    // Invalid address: err set, table unchanged, next start clears err
    step(0, 1, 7, 31, 0);
    step(0, 0, 0, 0, 0);
    chk("bad_addr_err", err, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("err_cleared", err, 0);
    idle_n(LEN + 2);
    chk("bad_addr_table", last_frame, exp_basic);

    // Write during SHIFT is rejected
    step(0, 0, 0, 0, 1);
    idle_n(5);
    step(0, 1, 2, 31, 0);
    step(0, 0, 0, 0, 0);
    chk("shift_wr_err", err, 1);
    idle_n(LEN);
    chk("shift_wr_inflight", last_frame, exp_basic);
    step(0, 0, 0, 0, 1);
    idle_n(LEN + 3);
    chk("shift_wr_kept", last_frame, exp_basic);

    // Reset at bit 10 of SHIFT
    step(0, 0, 0, 0, 1);
    idle_n(9);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ser_en", ser_en, 0);
    chk("abort_ser_out", ser_out, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    idle_n(LEN + 3);
    step(0, 0, 0, 0, 1);
    idle_n(LEN + 3);
    chk("post_reset_frame", last_frame, 0);

    // Start held through DONE: back-to-back identical frames
    for (int i = 0; i < 6; i++) step(0, 1, i, $urandom_range(0, 31), 0);
    exp_rand = table_frame();
    for (int i = 0; i < LEN + 3; i++) step(0, 0, 0, 0, 1);
    idle_n(LEN + 3);
    chk("b2b_first", prev_frame, exp_rand);
    chk("b2b_second", last_frame, exp_rand);
    chk("b2b_gap", done_cyc - prev_done_cyc, LEN + 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, we, st;
      int a, d;
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 7);
      d  = $urandom_range(0, 31);
      st = ($urandom_range(0, 9) == 0);
      // keep a rejected write off the cycle that launches a frame
      if (st && we && a > 5 && busy_left == 0) a = a - 2;
      step(r, we, a, d, st);
    end
    idle_n(LEN + 5);
    chk("queue_drain", expq.size(), 0);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
